// File: rtl/ila_refcheck_seq.sv
// ila_refcheck_seq
//   Control and sequencing core for ILA-vs-RTL refinement-check wrappers.
//   Issues a single start pulse, counts cycles since start, walks a chain of
//   N_STEP instruction windows (each ending at its own cycle), records sticky
//   per-mapping mismatches at each window end and flags a timeout when the
//   counter saturates before the final window closes.
//
//   Optional feature (macro REFCHECK_MEM_EN): adds mem_eq_i / mem_mismatch_o,
//   a sticky abstract-memory compare result folded into pass/fail.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   issue_i         request to begin the check (honoured once per reset)
//   end_cycles_i    packed end cycle per step, step k at [k*CNT_W +: CNT_W]
//   map_eq_i        per-mapping equality (ILA variable vs RTL signal)
//   map_en_i        per-mapping enable, sampled at each step end
//   start_o         one-cycle start pulse
//   started_o       sticky, high from the cycle after start
//   cycle_cnt_o     cycles since start, saturating at MAX_CYC
//   step_o          active step index
//   step_end_o      current step ends this cycle (combinational)
//   iend_o          final step ends this cycle (combinational)
//   ended_o         sticky, set after the final step end
//   ended2_o        sticky, one cycle behind ended_o
//   reseted_o       sticky, high after any reset cycle
//   compare_o       iend_o | ended_o, drives the abstract-memory compare
//   mismatch_o      sticky per-mapping failure record
//   timeout_o       sticky, counter saturated before the final step ended
//   pass_o, fail_o  overall verdict
module ila_refcheck_seq #(
  parameter int CNT_W   = 4,
  parameter int MAX_CYC = 6,
  parameter int N_MAP   = 16,
  parameter int N_STEP  = 2,
  localparam int STEP_W = (N_STEP > 1) ? $clog2(N_STEP) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_i,
  input  logic [N_STEP*CNT_W-1:0] end_cycles_i,
  input  logic [N_MAP-1:0]        map_eq_i,
  input  logic [N_MAP-1:0]        map_en_i,
`ifdef REFCHECK_MEM_EN
  input  logic                    mem_eq_i,
  output logic                    mem_mismatch_o,
`endif
  output logic                    start_o,
  output logic                    started_o,
  output logic [CNT_W-1:0]        cycle_cnt_o,
  output logic [STEP_W-1:0]       step_o,
  output logic                    step_end_o,
  output logic                    iend_o,
  output logic                    ended_o,
  output logic                    ended2_o,
  output logic                    reseted_o,
  output logic                    compare_o,
  output logic [N_MAP-1:0]        mismatch_o,
  output logic                    timeout_o,
  output logic                    pass_o,
  output logic                    fail_o
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cur_end;
  logic             last_step;
  logic             at_max;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // issue_i only matters in IDLE; once started the sequence never returns
  // there except through reset, so start_o cannot pulse twice.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue_i) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (iend_o) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign start_o   = (state == START);
  assign started_o = (state == RUN) || (state == DONE);

  always_comb begin
    cur_end = '0;
    for (int unsigned k = 0; k < N_STEP; k++)
      if (step_o == STEP_W'(k)) cur_end = end_cycles_i[k*CNT_W +: CNT_W];
  end

  assign last_step  = (step_o == STEP_W'(N_STEP - 1));
  assign at_max     = (cycle_cnt_o == CNT_W'(MAX_CYC));
  assign step_end_o = started_o & reseted_o & ~ended_o & (cycle_cnt_o == cur_end);
  assign iend_o     = step_end_o & last_step;
  assign compare_o  = iend_o | ended_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_o <= '0;
      step_o      <= '0;
      ended_o     <= 1'b0;
      ended2_o    <= 1'b0;
      mismatch_o  <= '0;
      timeout_o   <= 1'b0;
      reseted_o   <= 1'b1;
    end else begin
      if ((start_o | started_o) && (cycle_cnt_o < CNT_W'(MAX_CYC)))
        cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (step_end_o) begin
        mismatch_o <= mismatch_o | (map_en_i & ~map_eq_i);
        if (!last_step) step_o <= step_o + 1'b1;
      end
      if (iend_o) ended_o <= 1'b1;
      if (ended_o) ended2_o <= 1'b1;
      // A step end at the saturation cycle suppresses timeout, so a final
      // step landing exactly on MAX_CYC still counts as a clean end.
      if (at_max && started_o && !ended_o && !step_end_o) timeout_o <= 1'b1;
    end
  end

`ifdef REFCHECK_MEM_EN
  always_ff @(posedge clk) begin
    if (rst)                       mem_mismatch_o <= 1'b0;
    else if (compare_o && !mem_eq_i) mem_mismatch_o <= 1'b1;
  end

  assign fail_o = (|mismatch_o) | timeout_o | mem_mismatch_o;
  assign pass_o = ended_o & ~(|mismatch_o) & ~timeout_o & ~mem_mismatch_o;
`else
  assign fail_o = (|mismatch_o) | timeout_o;
  assign pass_o = ended_o & ~(|mismatch_o) & ~timeout_o;
`endif

endmodule

// File: tb/tb_ila_refcheck_seq.sv
// tb_ila_refcheck_seq
//   Directed bench for ila_refcheck_seq. Two instances share stimulus:
//   dut (N_STEP=2) for the step chain, and dut1 (N_STEP=1) for the basic
//   single-window pass case.
module tb_ila_refcheck_seq;

  logic        clk;
  logic        rst;
  logic        issue;
  logic [7:0]  end_cycles;
  logic [3:0]  u1_end;
  logic [15:0] map_eq;
  logic [15:0] map_en;

  logic        start, started, step_end, iend, ended, ended2, reseted;
  logic        compare, timeout, pass, fail;
  logic [3:0]  cnt;
  logic [0:0]  step;
  logic [15:0] mismatch;

  logic        u1_start, u1_started, u1_step_end, u1_iend, u1_ended, u1_ended2;
  logic        u1_reseted, u1_compare, u1_timeout, u1_pass, u1_fail;
  logic [3:0]  u1_cnt;
  logic [0:0]  u1_step;
  logic [15:0] u1_mismatch;

`ifdef REFCHECK_MEM_EN
  logic mem_eq;
  logic mem_mm, u1_mem_mm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ila_refcheck_seq #(.CNT_W(4), .MAX_CYC(6), .N_MAP(16), .N_STEP(2)) dut (
    .clk(clk), .rst(rst), .issue_i(issue), .end_cycles_i(end_cycles),
    .map_eq_i(map_eq), .map_en_i(map_en),
`ifdef REFCHECK_MEM_EN
    .mem_eq_i(mem_eq), .mem_mismatch_o(mem_mm),
`endif
    .start_o(start), .started_o(started), .cycle_cnt_o(cnt), .step_o(step),
    .step_end_o(step_end), .iend_o(iend), .ended_o(ended), .ended2_o(ended2),
    .reseted_o(reseted), .compare_o(compare), .mismatch_o(mismatch),
    .timeout_o(timeout), .pass_o(pass), .fail_o(fail)
  );

  ila_refcheck_seq #(.CNT_W(4), .MAX_CYC(6), .N_MAP(16), .N_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .issue_i(issue), .end_cycles_i(u1_end),
    .map_eq_i(map_eq), .map_en_i(map_en),
`ifdef REFCHECK_MEM_EN
    .mem_eq_i(mem_eq), .mem_mismatch_o(u1_mem_mm),
`endif
    .start_o(u1_start), .started_o(u1_started), .cycle_cnt_o(u1_cnt),
    .step_o(u1_step), .step_end_o(u1_step_end), .iend_o(u1_iend),
    .ended_o(u1_ended), .ended2_o(u1_ended2), .reseted_o(u1_reseted),
    .compare_o(u1_compare), .mismatch_o(u1_mismatch), .timeout_o(u1_timeout),
    .pass_o(u1_pass), .fail_o(u1_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are inspected 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    issue = 1'b0;
    tick();
    rst   = 1'b0;
  endtask

  // Issue and step into START (cnt=0); the next tick gives cnt=1.
  task automatic kick();
    issue = 1'b1;
    tick();
    issue = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"},    32'(start),    0);
    check({tag, "_started"},  32'(started),  0);
    check({tag, "_cnt"},      32'(cnt),      0);
    check({tag, "_step"},     32'(step),     0);
    check({tag, "_ended"},    32'(ended),    0);
    check({tag, "_ended2"},   32'(ended2),   0);
    check({tag, "_mismatch"}, 32'(mismatch), 0);
    check({tag, "_timeout"},  32'(timeout),  0);
    check({tag, "_pass"},     32'(pass),     0);
    check({tag, "_fail"},     32'(fail),     0);
    check({tag, "_reseted"},  32'(reseted),  1);
  endtask

  // end_cycles {4,2}; bit 3 of map_eq drops only at cnt=2.
  task automatic run_two_step(input string tag, input logic [15:0] en,
                              input logic [15:0] exp_mm, input logic exp_pass);
    do_reset();
    map_en     = en;
    map_eq     = 16'hFFFF;
    end_cycles = {4'd4, 4'd2};
    kick();
    tick();                          // cnt=1
    tick();                          // cnt=2
    map_eq = 16'hFFF7;
    #1;
    check({tag, "_se0"},   32'(step_end), 1);
    check({tag, "_step0"}, 32'(step),     0);
    check({tag, "_iend0"}, 32'(iend),     0);
    tick();                          // cnt=3
    map_eq = 16'hFFFF;
    check({tag, "_step1"}, 32'(step),     1);
    check({tag, "_mm_mid"}, 32'(mismatch), 32'(exp_mm));
    tick();                          // cnt=4
    check({tag, "_iend1"}, 32'(iend),    1);
    check({tag, "_cnt4"},  32'(cnt),     4);
    tick();
    check({tag, "_ended"}, 32'(ended),    1);
    check({tag, "_mm"},    32'(mismatch), 32'(exp_mm));
    check({tag, "_pass"},  32'(pass),     32'(exp_pass));
    check({tag, "_fail"},  32'(fail),     32'(!exp_pass));
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    issue      = 1'b0;
    end_cycles = {4'd4, 4'd2};
    u1_end     = 4'd1;
    map_eq     = 16'hFFFF;
    map_en     = 16'hFFFF;
`ifdef REFCHECK_MEM_EN
    mem_eq     = 1'b1;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("rst");

    // Basic single-window pass on dut1, end cycle 1.
    kick();
    check("b_start",   32'(u1_start),   1);
    check("b_started", 32'(u1_started), 0);
    check("b_cnt0",    32'(u1_cnt),     0);
    tick();
    check("b_start_off", 32'(u1_start),   0);
    check("b_started1",  32'(u1_started), 1);
    check("b_cnt1",      32'(u1_cnt),     1);
    check("b_iend",      32'(u1_iend),    1);
    check("b_compare",   32'(u1_compare), 1);
    check("b_ended_pre", 32'(u1_ended),   0);
    tick();
    check("b_ended",   32'(u1_ended),  1);
    check("b_pass",    32'(u1_pass),   1);
    check("b_ended2a", 32'(u1_ended2), 0);
    tick();
    check("b_ended2", 32'(u1_ended2), 1);
    check("b_fail",   32'(u1_fail),   0);

    run_two_step("mm",   16'hFFFF, 16'h0008, 1'b0);
    run_two_step("mask", 16'hFFF7, 16'h0000, 1'b1);

    // Final step lands exactly on MAX_CYC: clean end, no timeout.
    do_reset();
    map_en     = 16'hFFFF;
    end_cycles = {4'd6, 4'd2};
    kick();
    for (int i = 0; i < 6; i++) tick();
    check("edge_cnt",  32'(cnt),  6);
    check("edge_iend", 32'(iend), 1);
    tick();
    check("edge_ended",   32'(ended),   1);
    check("edge_timeout", 32'(timeout), 0);
    check("edge_pass",    32'(pass),    1);

    // Timeout: second window at 7 is beyond saturation.
    do_reset();
    end_cycles = {4'd7, 4'd2};
    kick();
    for (int i = 0; i < 6; i++) tick();
    check("to_cnt6",  32'(cnt),     6);
    check("to_early", 32'(timeout), 0);
    tick();
    check("to_set", 32'(timeout), 1);
    for (int i = 0; i < 3; i++) tick();
    check("to_hold",  32'(cnt),   6);
    check("to_ended", 32'(ended), 0);
    check("to_step",  32'(step),  1);
    check("to_fail",  32'(fail),  1);
    check("to_pass",  32'(pass),  0);

    // Reset mid-run at cnt=3, then restart.
    do_reset();
    end_cycles = {4'd4, 4'd2};
    map_eq     = 16'hFFFE;
    kick();
    for (int i = 0; i < 3; i++) tick();
    check("mr_cnt3", 32'(cnt),      3);
    check("mr_mm",   32'(mismatch), 1);
    map_eq = 16'hFFFF;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    check_reset_state("mr");
    tick();
    check("mr_idle", 32'(start), 0);
    kick();
    check("mr_restart", 32'(start), 1);
    tick();
    check("mr_pulse_end", 32'(start),   0);
    check("mr_started",   32'(started), 1);

    // issue held for 10 cycles: exactly one start pulse.
    do_reset();
    issue  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start) pulses++;
    end
    issue = 1'b0;
    check("rep_pulses", 32'(pulses), 1);
    check("rep_pass",   32'(pass),   1);
`ifdef REFCHECK_MEM_EN
    mem_eq = 1'b0;
    tick();
    mem_eq = 1'b1;
    check("mem_mm",   32'(mem_mm), 1);
    check("mem_fail", 32'(fail),   1);
    check("mem_pass", 32'(pass),   0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
